h75_plane_shifter: RTL and testbench
====================================

H75_PLANE_SHIFTER -- requirements
Module: h75_plane_shifter

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning bits per colour channel in RAM words (plane index 7..0 valid).
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port frame_sync  in  1  frame start from timing generator.
REQ-005 SHALL have port plane  in  3  bit-plane index currently shifted.
REQ-006 SHALL have port rd_addr  in  14  {row[4:0], x[8:0]} from timing generator.
REQ-007 SHALL have port rd_valid  in  1  pixel data on ram_rdata is valid this cycle.
REQ-008 SHALL have port pixels_per_row  in  10  expected pixels per row.
REQ-009 SHALL have port ram_addr  out  15  {bank, rd_addr} to frame RAM (combinational).
REQ-010 SHALL have port ram_rdata  in  6*PIX_W  {upper R,G,B, lower R,G,B}, MSB first.
REQ-011 SHALL have ports swap_req  in  1 / swap_ack  out  1  buffer-swap handshake.
REQ-012 SHALL have port bank  out  1  bank currently displayed.
REQ-013 SHALL have ports R0,G0,B0,R1,G1,B1  out  1 each  panel colour data.
REQ-014 SHALL have ports row_underrun  out  1 sticky error / row_count  out  10 pixels shifted in last row.

Function
REQ-015 Each rising clk with rd_valid=1 SHALL register bit [plane] of each channel of ram_rdata into R0..B1; outputs SHALL hold when rd_valid=0.
REQ-016 plane values above PIX_W-1 SHALL drive all colour outputs 0.
REQ-017 A 10-bit pixel counter SHALL increment on each rd_valid=1 cycle and saturate at 1023.
REQ-018 On rd_valid falling (registered 1 -> current 0), row_count SHALL load the counter value and the counter SHALL clear the same cycle.
REQ-019 If the loaded value differs from pixels_per_row, row_underrun SHALL set and stay set until reset or frame_sync rising edge with no mismatch that cycle.
REQ-020 Swap FSM states: IDLE, PENDING, ACK.
REQ-021 IDLE -> PENDING when swap_req=1.
REQ-022 PENDING -> ACK on frame_sync rising edge (registered 0 -> current 1); bank SHALL toggle on that same edge.
REQ-023 ACK: swap_ack=1 for exactly one cycle, then -> IDLE if swap_req=0, else remain in a wait-for-release sub-condition (swap_ack=0) until swap_req=0 before IDLE.
REQ-024 bank SHALL never change except per REQ-022; one swap per frame_sync edge maximum.
REQ-025 swap_req deasserted while PENDING SHALL return FSM to IDLE with no swap.
REQ-026 frame_sync edge while rd_valid=1 SHALL still swap; ram_addr bank bit changes on the following cycle.

Reset
REQ-027 resetn=0 SHALL asynchronously force R0..B1=0, bank=0, swap_ack=0, row_count=0, row_underrun=0, counter=0, FSM=IDLE, edge-detect registers=0.
REQ-028 Reset mid-row or mid-handshake SHALL abandon the pending swap; first valid operation resumes after resetn returns 1.

Configuration
REQ-029 Macro H75_TEST_PATTERN_EN SHALL, when defined, add input test_en (1 bit); with test_en=1 colour outputs SHALL be R=x[5], G=x[6], B=x[7] of rd_addr (both halves), ignoring ram_rdata, still gated by rd_valid.
REQ-030 Without H75_TEST_PATTERN_EN, test_en SHALL not exist and outputs SHALL come only from ram_rdata.

Verification
REQ-031 plane=7, ram_rdata upper R=0x80 others 0, rd_valid 1 cycle -> R0=1, others 0, held afterwards.
REQ-032 pixels_per_row=64, rd_valid high 64 cycles -> row_count=64, row_underrun=0; repeat with 63 cycles -> row_underrun=1.
REQ-033 swap_req=1, then frame_sync pulse -> bank 0->1 on edge, swap_ack one-cycle pulse, ram_addr[14]=1 next cycle.
REQ-034 swap_req pulsed and dropped before frame_sync -> bank stays 0, swap_ack never asserted.
REQ-035 resetn low while PENDING and rd_valid=1 -> all outputs 0 immediately; later frame_sync does not swap.
REQ-036 H75_TEST_PATTERN_EN defined, test_en=1, rd_addr x=0xA0 -> R=1, G=0, B=1 on both halves.

Source files
------------

// File: rtl/h75_plane_shifter.sv
// -----------------------------------------------------------------------------
// h75_plane_shifter
//
// Purpose:
//   Bit-plane shifter for a HUB75-style LED panel. Picks one bit-plane out of
//   the frame-RAM pixel word and registers it onto the six panel colour lines.
//   It also counts pixels per row and flags short/long rows. A small handshake
//   FSM swaps the displayed RAM bank on a frame boundary.
//
// Optional feature:
//   H75_TEST_PATTERN_EN - when defined, adds input test_en. With test_en=1 the
//   colour lines carry a bar pattern taken from rd_addr x bits instead of RAM
//   data.
//
// Ports:
//   clk            in   system clock, all logic on rising edge
//   resetn         in   asynchronous active-low reset
//   frame_sync     in   frame start from timing generator (rising edge used)
//   plane          in   bit-plane index being shifted
//   rd_addr        in   {row[4:0], x[8:0]} from timing generator
//   rd_valid       in   ram_rdata carries a pixel this cycle
//   pixels_per_row in   expected pixel count per row
//   ram_addr       out  {bank, rd_addr} to frame RAM (combinational)
//   ram_rdata      in   {upper R,G,B, lower R,G,B}, PIX_W bits each, MSB first
//   swap_req       in   request to swap displayed bank
//   swap_ack       out  one-cycle acknowledge of a completed swap
//   bank           out  bank currently displayed
//   R0,G0,B0       out  upper-half colour data
//   R1,G1,B1       out  lower-half colour data
//   row_underrun   out  sticky row length error
//   row_count      out  pixels shifted in the last completed row
//   test_en        in   (H75_TEST_PATTERN_EN only) select bar test pattern
//
// Swap FSM states:
//   state      | meaning
//   ST_IDLE    | no swap requested
//   ST_PENDING | swap_req seen, waiting for frame_sync rising edge
//   ST_ACK     | bank just toggled; swap_ack high on entry cycle only
//              | (r_ack_wait=0), then waits for swap_req release (r_ack_wait=1)
// -----------------------------------------------------------------------------
module h75_plane_shifter #(
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 frame_sync,
    input  logic [2:0]           plane,
    input  logic [13:0]          rd_addr,
    input  logic                 rd_valid,
    input  logic [9:0]           pixels_per_row,
    output logic [14:0]          ram_addr,
    input  logic [6*PIX_W-1:0]   ram_rdata,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 bank,
    output logic                 R0,
    output logic                 G0,
    output logic                 B0,
    output logic                 R1,
    output logic                 G1,
    output logic                 B1,
    output logic                 row_underrun,
    output logic [9:0]           row_count
`ifdef H75_TEST_PATTERN_EN
    ,
    input  logic                 test_en
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } swap_state_t;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    swap_state_t r_state;
    swap_state_t w_state_nxt;
    logic        r_ack_wait;
    logic        w_ack_wait_nxt;
    logic        w_bank_toggle;
    logic        w_swap_ack;
    logic        r_bank;

    logic        r_frame_sync_d;
    logic        r_rd_valid_d;
    logic        w_fs_rise;
    logic        w_row_end;
    logic        w_row_mismatch;

    logic [9:0]  r_pix_cnt;
    logic [9:0]  r_row_count;
    logic        r_row_underrun;

    logic [PIX_W-1:0] w_plane_mask;
    logic             w_plane_ok;
    logic [5:0]       w_plane_bits;
    logic [5:0]       w_rgb_src;
    logic [5:0]       r_rgb;

    // -------------------------------------------------------------------------
    // Bit-plane extraction. Channel c occupies ram_rdata[c*PIX_W +: PIX_W];
    // c=5 is upper R (MSB end) down to c=0 lower B, so w_plane_bits is already
    // ordered {R0,G0,B0,R1,G1,B1}.
    // -------------------------------------------------------------------------
    assign w_plane_mask = {{(PIX_W-1){1'b0}}, 1'b1} << plane;
    assign w_plane_ok   = (int'(plane) < PIX_W);

    for (genvar c = 0; c < 6; c++) begin : g_chan
        assign w_plane_bits[c] = |(ram_rdata[c*PIX_W +: PIX_W] & w_plane_mask);
    end

`ifdef H75_TEST_PATTERN_EN
    logic [5:0] w_pattern;

    // Bars from x[7:5]; the same pattern is sent to both panel halves.
    assign w_pattern = {rd_addr[5], rd_addr[6], rd_addr[7],
                        rd_addr[5], rd_addr[6], rd_addr[7]};
    assign w_rgb_src = test_en    ? w_pattern    :
                       w_plane_ok ? w_plane_bits : 6'd0;
`else
    assign w_rgb_src = w_plane_ok ? w_plane_bits : 6'd0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rgb <= 6'd0;
        end else if (rd_valid) begin
            r_rgb <= w_rgb_src;
        end
    end

    // -------------------------------------------------------------------------
    // Edge detection
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_sync_d <= 1'b0;
            r_rd_valid_d   <= 1'b0;
        end else begin
            r_frame_sync_d <= frame_sync;
            r_rd_valid_d   <= rd_valid;
        end
    end

    assign w_fs_rise      = frame_sync & ~r_frame_sync_d;
    assign w_row_end      = r_rd_valid_d & ~rd_valid;
    assign w_row_mismatch = w_row_end & (r_pix_cnt != pixels_per_row);

    // -------------------------------------------------------------------------
    // Row pixel counter and row length check
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pix_cnt <= 10'd0;
        end else if (rd_valid) begin
            if (r_pix_cnt != CNT_MAX) begin
                r_pix_cnt <= r_pix_cnt + 10'd1;
            end
        end else if (w_row_end) begin
            r_pix_cnt <= 10'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_row_count <= 10'd0;
        end else if (w_row_end) begin
            r_row_count <= r_pix_cnt;
        end
    end

    // A mismatch on the same cycle as a frame edge wins, so the error is
    // never lost across the frame boundary.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_row_underrun <= 1'b0;
        end else if (w_row_mismatch) begin
            r_row_underrun <= 1'b1;
        end else if (w_fs_rise) begin
            r_row_underrun <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Swap FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_ack_wait <= 1'b0;
            r_bank     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ack_wait <= w_ack_wait_nxt;
            if (w_bank_toggle) begin
                r_bank <= ~r_bank;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ack_wait_nxt = r_ack_wait;
        w_bank_toggle  = 1'b0;
        w_swap_ack     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ack_wait_nxt = 1'b0;
                if (swap_req) begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Dropping the request cancels it, even on a frame edge.
                if (!swap_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_fs_rise) begin
                    w_state_nxt    = ST_ACK;
                    w_bank_toggle  = 1'b1;
                    w_ack_wait_nxt = 1'b0;
                end
            end
            ST_ACK: begin
                w_swap_ack = ~r_ack_wait;
                if (!swap_req) begin
                    w_state_nxt    = ST_IDLE;
                    w_ack_wait_nxt = 1'b0;
                end else begin
                    w_ack_wait_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_ack_wait_nxt = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ram_addr     = {r_bank, rd_addr};
    assign bank         = r_bank;
    assign swap_ack     = w_swap_ack;
    assign row_count    = r_row_count;
    assign row_underrun = r_row_underrun;
    assign R0           = r_rgb[5];
    assign G0           = r_rgb[4];
    assign B0           = r_rgb[3];
    assign R1           = r_rgb[2];
    assign G1           = r_rgb[1];
    assign B1           = r_rgb[0];

endmodule

// File: tb/tb_h75_plane_shifter.sv
module tb_h75_plane_shifter;

    logic        clk;
    logic        resetn;
    logic        frame_sync;
    logic [2:0]  plane;
    logic [13:0] rd_addr;
    logic        rd_valid;
    logic [9:0]  pixels_per_row;
    logic [14:0] ram_addr;
    logic [47:0] ram_rdata;
    logic        swap_req;
    logic        swap_ack;
    logic        bank;
    logic        R0, G0, B0, R1, G1, B1;
    logic        row_underrun;
    logic [9:0]  row_count;
`ifdef H75_TEST_PATTERN_EN
    logic        test_en;
`endif

    h75_plane_shifter #(.PIX_W(8)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .frame_sync     (frame_sync),
        .plane          (plane),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .pixels_per_row (pixels_per_row),
        .ram_addr       (ram_addr),
        .ram_rdata      (ram_rdata),
        .swap_req       (swap_req),
        .swap_ack       (swap_ack),
        .bank           (bank),
        .R0             (R0),
        .G0             (G0),
        .B0             (B0),
        .R1             (R1),
        .G1             (G1),
        .B1             (B1),
        .row_underrun   (row_underrun),
        .row_count      (row_count)
`ifdef H75_TEST_PATTERN_EN
        ,
        .test_en        (test_en)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] cnt;
        logic       under;
    } row_exp_t;

    typedef struct packed {
        logic bank;
        logic ack;
        logic under;
    } fs_exp_t;

    logic [5:0] q_pix[$];
    row_exp_t   q_row[$];
    fs_exp_t    q_fs[$];

    int n_tests    = 0;
    int n_fail     = 0;
    int n_ack_exp  = 0;
    int n_ack_seen = 0;

    // stimulus for the next clock edge
    logic        d_v, d_fs, d_req, d_test;
    logic [2:0]  d_pl;
    logic [47:0] d_data;
    logic [13:0] d_addr;
    logic [9:0]  d_ppr;

    // reference model state
    logic m_prev_v, m_prev_fs, m_prev_req, m_served, m_bank, m_under;
    int   m_len;
    int   g_fs_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Colour for one pixel: bit 'pl' of each channel, or the x-bar pattern.
    function automatic logic [5:0] exp_rgb(input logic [2:0] pl, input logic [47:0] d,
                                           input logic [13:0] a, input logic te);
        logic [7:0] ur, ug, ub, lr, lg, lb;
        if (te) return {a[5], a[6], a[7], a[5], a[6], a[7]};
        ur = d[47:40]; ug = d[39:32]; ub = d[31:24];
        lr = d[23:16]; lg = d[15:8];  lb = d[7:0];
        return {ur[pl], ug[pl], ub[pl], lr[pl], lg[pl], lb[pl]};
    endfunction

    task automatic model_reset();
        m_prev_v = 0; m_prev_fs = 0; m_prev_req = 0;
        m_served = 0; m_bank = 0; m_under = 0; m_len = 0;
    endtask

    // Apply d_* for the next edge and predict what that edge produces.
    task automatic cyc();
        logic     row_end, fsr, swp, mism;
        logic [9:0] cnt;
        row_exp_t er;
        fs_exp_t  ef;
        @(posedge clk);
        #1;
        rd_valid       = d_v;
        plane          = d_pl;
        ram_rdata      = d_data;
        rd_addr        = d_addr;
        frame_sync     = d_fs;
        swap_req       = d_req;
        pixels_per_row = d_ppr;
`ifdef H75_TEST_PATTERN_EN
        test_en        = d_test;
`endif
        row_end = m_prev_v && !d_v;
        cnt     = (m_len > 1023) ? 10'd1023 : 10'(m_len);
        mism    = row_end && (cnt != d_ppr);
        if (d_v) begin
            q_pix.push_back(exp_rgb(d_pl, d_data, d_addr, d_test));
            m_len++;
        end
        fsr = d_fs && !m_prev_fs;
        // a swap needs a request that was already registered and not yet served
        swp = fsr && d_req && m_prev_req && !m_served;
        if (!d_req) m_served = 0;
        if (swp) begin
            m_served = 1;
            m_bank   = !m_bank;
            n_ack_exp++;
        end
        if (mism) m_under = 1;
        else if (fsr) m_under = 0;
        if (row_end) begin
            er.cnt = cnt; er.under = m_under;
            q_row.push_back(er);
            m_len = 0;
        end
        if (fsr) begin
            ef.bank = m_bank; ef.ack = swp; ef.under = m_under;
            q_fs.push_back(ef);
        end
        m_prev_v = d_v; m_prev_fs = d_fs; m_prev_req = d_req;
    endtask

    task automatic idle(input int n);
        d_v = 0; d_fs = 0;
        repeat (n) cyc();
    endtask

    task automatic gen_ctrl();
        if (g_fs_cnt > 0) begin
            d_fs = 1;
            g_fs_cnt--;
        end else begin
            d_fs = 0;
            if ($urandom_range(0, 24) == 0) g_fs_cnt = $urandom_range(1, 3);
        end
        if ($urandom_range(0, 11) == 0) d_req = !d_req;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rgb"},   32'({R0, G0, B0, R1, G1, B1}), 32'd0);
        chk({tag, "_bank"},  32'(bank), 32'd0);
        chk({tag, "_ack"},   32'(swap_ack), 32'd0);
        chk({tag, "_rowc"},  32'(row_count), 32'd0);
        chk({tag, "_under"}, 32'(row_underrun), 32'd0);
        chk({tag, "_abank"}, 32'(ram_addr[14]), 32'd0);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3;
        resetn = 0;
        #1;
        check_all_zero("rst_mid");
        d_v = 0; d_fs = 0; d_req = 0;
        rd_valid = 0; frame_sync = 0; swap_req = 0;
        q_pix.delete(); q_row.delete(); q_fs.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1;
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        logic mp_v, mp_fs, cur_v, rend, fsr, ack_low, mb;
        logic [5:0] m_rgb;
        logic [5:0] ep;
        row_exp_t   er;
        fs_exp_t    ef;
        mp_v = 0; mp_fs = 0; m_rgb = 0; mb = 0; ack_low = 0;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                mp_v = 0; mp_fs = 0; m_rgb = 0; mb = 0; ack_low = 0;
            end else begin
                cur_v = rd_valid;
                rend  = mp_v && !rd_valid;
                fsr   = frame_sync && !mp_fs;
                mp_v  = rd_valid;
                mp_fs = frame_sync;
                @(negedge clk);
                if (resetn) begin
                    if (cur_v) begin
                        if (q_pix.size() == 0) begin
                            chk("pix_queue_empty", 32'd1, 32'd0);
                        end else begin
                            ep = q_pix.pop_front();
                            chk("pix", 32'({R0, G0, B0, R1, G1, B1}), 32'(ep));
                            m_rgb = ep;
                        end
                    end else begin
                        chk("pix_hold", 32'({R0, G0, B0, R1, G1, B1}), 32'(m_rgb));
                    end
                    if (rend) begin
                        if (q_row.size() == 0) begin
                            chk("row_queue_empty", 32'd1, 32'd0);
                        end else begin
                            er = q_row.pop_front();
                            chk("row_count", 32'(row_count), 32'(er.cnt));
                            chk("row_underrun", 32'(row_underrun), 32'(er.under));
                        end
                    end
                    if (ack_low) begin
                        chk("ack_one_cycle", 32'(swap_ack), 32'd0);
                        ack_low = 0;
                    end
                    if (fsr) begin
                        if (q_fs.size() == 0) begin
                            chk("fs_queue_empty", 32'd1, 32'd0);
                        end else begin
                            ef = q_fs.pop_front();
                            mb = ef.bank;
                            chk("fs_ack", 32'(swap_ack), 32'(ef.ack));
                            chk("fs_underrun", 32'(row_underrun), 32'(ef.under));
                            ack_low = ef.ack;
                        end
                    end
                    chk("bank", 32'(bank), 32'(mb));
                    chk("ram_addr", 32'(ram_addr), 32'({mb, rd_addr}));
                    if (swap_ack) n_ack_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : driver
        int len;
        int gap;
        resetn = 0; frame_sync = 0; plane = 0; rd_addr = 0; rd_valid = 0;
        pixels_per_row = 0; ram_rdata = 0; swap_req = 0;
`ifdef H75_TEST_PATTERN_EN
        test_en = 0;
`endif
        d_v = 0; d_fs = 0; d_req = 0; d_test = 0; d_pl = 0; d_data = 0;
        d_addr = 0; d_ppr = 10'd64; g_fs_cnt = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1;

        // plane 7, upper R = 0x80 for one cycle, then hold
        d_ppr = 10'd64; d_v = 1; d_pl = 3'd7; d_data = 48'h80_00_00_00_00_00;
        d_addr = 14'h0123;
        cyc();
        idle(4);
        d_fs = 1; cyc(); idle(3);

        // exact 64-pixel row, then a short 63-pixel row
        d_data = 48'hFF_00_FF_00_FF_00; d_pl = 3'd2;
        d_v = 1; repeat (64) cyc();
        idle(3);
        d_v = 1; repeat (63) cyc();
        idle(3);
        d_fs = 1; cyc(); idle(3);

        // request pulsed and withdrawn before the frame edge
        d_req = 1; cyc();
        d_req = 0; idle(3);
        d_fs = 1; cyc(); idle(3);

        // full swap with the request held past the acknowledge
        d_req = 1; idle(3);
        d_fs = 1; cyc();
        d_fs = 0; idle(3);
        d_req = 0; idle(3);

        // reset while a swap is pending and pixels are streaming
        d_req = 1; idle(2);
        d_v = 1; d_pl = 3'd0; d_data = 48'hFF_FF_FF_FF_FF_FF;
        repeat (3) cyc();
        reset_mid();
        d_fs = 1; cyc(); idle(3);

`ifdef H75_TEST_PATTERN_EN
        d_test = 1; d_v = 1; d_data = {16'($urandom()), $urandom()};
        d_addr = {5'd3, 9'h0A0};
        cyc();
        d_addr = {5'd3, 9'h040}; cyc();
        d_test = 0; idle(3);
`endif

        // randomized rows with random swap requests and frame edges
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, 80);
            d_ppr = ($urandom_range(0, 1) == 1) ? 10'(len) : 10'($urandom_range(1, 80));
            for (int i = 0; i < len; i++) begin
                d_v = 1;
                d_pl = 3'($urandom_range(0, 7));
                d_data = {16'($urandom()), $urandom()};
                d_addr = 14'($urandom());
`ifdef H75_TEST_PATTERN_EN
                d_test = ($urandom_range(0, 7) == 0);
`endif
                gen_ctrl();
                cyc();
            end
            gap = $urandom_range(1, 4);
            for (int i = 0; i < gap; i++) begin
                d_v = 0;
                d_addr = 14'($urandom());
                gen_ctrl();
                cyc();
            end
        end
        d_req = 0; d_test = 0; g_fs_cnt = 0;
        idle(4);

        // counter saturation at 1023
        d_ppr = 10'd1023;
        for (int i = 0; i < 1030; i++) begin
            d_v = 1;
            d_pl = 3'($urandom_range(0, 7));
            d_data = {16'($urandom()), $urandom()};
            d_addr = 14'($urandom());
            cyc();
        end
        idle(3);
        d_fs = 1; cyc();
        idle(10);

        chk("pix_queue_drained", 32'(q_pix.size()), 32'd0);
        chk("row_queue_drained", 32'(q_row.size()), 32'd0);
        chk("fs_queue_drained",  32'(q_fs.size()),  32'd0);
        chk("ack_pulse_total",   32'(n_ack_seen),   32'(n_ack_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
